// File: rtl/click_pkg.sv
// Shared constants and state encodings for the click reporter.
// Imported by the UART byte transmitter and the top level.
package click_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [3:0] COUNT_MAX  = 4'd9;

  typedef enum logic [1:0] {
    MSG_IDLE,
    SEND_DIGIT,
    SEND_CR,
    SEND_LF
  } msg_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Mod-10 step; simultaneous up and down cancel out.
  function automatic logic [3:0] count_next(
    input logic [3:0] cur,
    input logic       up,
    input logic       down
  );
    logic [3:0] nxt;
    nxt = cur;
    unique case (1'b1)
      (up & ~down): nxt = (cur == COUNT_MAX) ? 4'd0 : cur + 4'd1;
      (down & ~up): nxt = (cur == 4'd0) ? COUNT_MAX : cur - 4'd1;
      default:      nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/click_reporter_if.sv
// Button inputs and reporting outputs of the click reporter.
// The bench drives the master side, the design sits on the slave side.
interface click_reporter_if;

  logic       UP;
  logic       DOWN;
  logic       UART_TX;
  logic [3:0] COUNT;
  logic       BUSY;

  modport master (
    output UP,
    output DOWN,
    input  UART_TX,
    input  COUNT,
    input  BUSY
  );

  modport slave (
    input  UP,
    input  DOWN,
    output UART_TX,
    output COUNT,
    output BUSY
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1 byte transmitter, LSB first, CLKS_PER_BIT cycles per bit.
// The last stop-bit cycle is spent in IDLE so a queued byte follows gap-free.
module uart_tx
  import click_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  tx_state_t     state;
  logic [CW-1:0] baud;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  assign READY = (state == TX_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= TX_IDLE;
      TX    <= 1'b1;
      baud  <= '0;
      idx   <= 3'd0;
      shreg <= 8'd0;
    end else begin
      unique case (state)
        TX_IDLE: begin
          if (VALID) begin
            shreg <= DATA;
            TX    <= 1'b0;
            baud  <= '0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (baud == LAST) begin
            baud  <= '0;
            idx   <= 3'd0;
            TX    <= shreg[0];
            shreg <= shreg >> 1;
            state <= TX_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud == LAST) begin
            baud <= '0;
            if (idx == 3'd7) begin
              TX    <= 1'b1;
              state <= TX_STOP;
            end else begin
              idx   <= idx + 3'd1;
              TX    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud == STOP_LAST) begin
            baud  <= '0;
            state <= TX_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/click_reporter.sv
// Mod-10 up/down click counter that reports each new value over UART
// as digit, CR, LF; changes during a message coalesce into one follow-up.
module click_reporter
  import click_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic             CLK,
  input  logic             RST_N,
  click_reporter_if.slave  io
);

  logic       up_prev;
  logic       down_prev;
  logic       pending;
  logic       busy;
  logic [3:0] count;
  msg_state_t state;

  logic       up_rise;
  logic       down_rise;
  logic       changed;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       accept;
  logic       start_msg;

  assign up_rise   = io.UP & ~up_prev;
  assign down_rise = io.DOWN & ~down_prev;
  assign changed   = up_rise ^ down_rise;
  assign accept    = tx_valid & tx_ready;
  assign start_msg = (state == MSG_IDLE) & accept;

  // The digit is taken from COUNT in the very cycle it is accepted.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = ASCII_ZERO + {4'd0, count};
    unique case (state)
      MSG_IDLE:   tx_valid = pending;
      SEND_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
      end
      SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
      end
      SEND_LF:    tx_valid = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      up_prev   <= 1'b1;
      down_prev <= 1'b1;
      count     <= 4'd0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      state     <= MSG_IDLE;
    end else begin
      up_prev   <= io.UP;
      down_prev <= io.DOWN;
      if (changed) begin
        count <= count_next(count, up_rise, down_rise);
      end
      pending <= changed | (pending & ~start_msg);
      unique case (state)
        MSG_IDLE: begin
          if (accept) begin
            state <= SEND_DIGIT;
            busy  <= 1'b1;
          end
        end
        SEND_DIGIT: if (accept) state <= SEND_CR;
        SEND_CR:    if (accept) state <= SEND_LF;
        SEND_LF: begin
          if (tx_ready) begin
            state <= MSG_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .CLK  (CLK),
    .RST_N(RST_N),
    .DATA (tx_data),
    .VALID(tx_valid),
    .READY(tx_ready),
    .TX   (tx_line)
  );

  assign io.UART_TX = tx_line;
  assign io.COUNT   = count;
  assign io.BUSY    = busy;

endmodule

// File: tb/tb_click_reporter.sv
// Bench for click_reporter: a UART monitor pops expected bytes
// from a scoreboard queue filled as button stimulus is driven.
module tb_click_reporter;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  click_reporter_if io();

  click_reporter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .io   (io.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  initial begin : monitor
    logic [7:0] b;
    logic       abort;
    logic       stop;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && io.UART_TX === 1'b0) begin
        abort = 1'b0;
        b = 8'd0;
        repeat (CPB / 2) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
          end
          b[i] = io.UART_TX;
        end
        repeat (CPB) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
        end
        stop = io.UART_TX;
        if (!abort) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL uart_byte: got %h, expected no byte", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e) begin
              errors++;
              $display("FAIL uart_byte: got %h, expected %h", b, e);
            end
          end
          checks++;
          if (stop !== 1'b1) begin
            errors++;
            $display("FAIL uart_stop: got %b, expected 1", stop);
          end
        end
      end
    end
  end

  task automatic push_msg(input logic [3:0] d);
    exp_q.push_back(8'h30 + {4'd0, d});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    io.UP = 1'b0;
    io.DOWN = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_up();
    @(negedge clk) io.UP = 1'b1;
    @(negedge clk) io.UP = 1'b0;
  endtask

  task automatic pulse_down();
    @(negedge clk) io.DOWN = 1'b1;
    @(negedge clk) io.DOWN = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && io.BUSY === 1'b0) break;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io.UP = 1'b0;
    io.DOWN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (io.COUNT !== 4'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", io.COUNT);
    end
    checks++;
    if (io.UART_TX !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b, expected 1", io.UART_TX);
    end
    checks++;
    if (io.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, expected 0", io.BUSY);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (io.COUNT !== 4'd0 || io.UART_TX !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got count %0d tx %b, expected 0 1",
               io.COUNT, io.UART_TX);
    end
  endtask

  task automatic test_single();
    int n;
    int start_i;
    logic first_tx;
    do_reset();
    push_msg(4'd1);
    n = 0;
    start_i = -1;
    first_tx = 1'b1;
    @(negedge clk) io.UP = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (io.COUNT !== 4'd1 || io.BUSY !== 1'b0 || io.UART_TX !== 1'b1) begin
      errors++;
      $display("FAIL single_edge: got count %0d busy %b tx %b, expected 1 0 1",
               io.COUNT, io.BUSY, io.UART_TX);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) io.UP = 1'b0;
      if (io.BUSY === 1'b1) begin
        if (n == 0) begin
          first_tx = io.UART_TX;
          start_i = i;
        end
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    checks++;
    if (start_i != 1 || first_tx !== 1'b0) begin
      errors++;
      $display("FAIL single_start: got cycle %0d tx %b, expected 1 0",
               start_i, first_tx);
    end
    checks++;
    if (n != 30 * CPB) begin
      errors++;
      $display("FAIL single_busy_len: got %0d, expected %0d", n, 30 * CPB);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_sequence();
    logic [3:0] exp;
    do_reset();
    exp = 4'd0;
    for (int k = 0; k < 10; k++) begin
      exp = (exp == 4'd9) ? 4'd0 : exp + 4'd1;
      push_msg(exp);
      pulse_up();
      checks++;
      if (io.COUNT !== exp) begin
        errors++;
        $display("FAIL seq_count: got %0d, expected %0d", io.COUNT, exp);
      end
      repeat (200) @(negedge clk);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL seq_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_down_and_both();
    logic seen;
    do_reset();
    push_msg(4'd9);
    pulse_down();
    checks++;
    if (io.COUNT !== 4'd9) begin
      errors++;
      $display("FAIL down_wrap: got %0d, expected 9", io.COUNT);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL down_drain: got %0d left, expected 0", exp_q.size());
    end
    @(negedge clk);
    io.UP = 1'b1;
    io.DOWN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      io.UP = 1'b0;
      io.DOWN = 1'b0;
      if (io.UART_TX !== 1'b1 || io.BUSY !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (io.COUNT !== 4'd9) begin
      errors++;
      $display("FAIL both_count: got %0d, expected 9", io.COUNT);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL both_quiet: got activity %b, expected 0", seen);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    push_msg(4'd1);
    push_msg(4'd4);
    pulse_up();
    repeat (3) begin
      repeat (10) @(negedge clk);
      pulse_up();
    end
    checks++;
    if (io.COUNT !== 4'd4 || io.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL coalesce_count: got %0d busy %b, expected 4 1",
               io.COUNT, io.BUSY);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL coalesce_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_held();
    rst_n = 1'b0;
    io.UP = 1'b1;
    io.DOWN = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (io.COUNT !== 4'd0 || io.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL held_count: got %0d busy %b, expected 0 0",
               io.COUNT, io.BUSY);
    end
    io.UP = 1'b0;
    repeat (3) @(negedge clk);
    push_msg(4'd1);
    pulse_up();
    checks++;
    if (io.COUNT !== 4'd1) begin
      errors++;
      $display("FAIL held_press: got %0d, expected 1", io.COUNT);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    exp_q.push_back(8'h31);
    @(negedge clk) io.UP = 1'b1;
    @(posedge clk);
    @(negedge clk) io.UP = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (io.BUSY !== 1'b1 || io.UART_TX !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: got busy %b tx %b, expected 1 0",
               io.BUSY, io.UART_TX);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.UART_TX !== 1'b1 || io.BUSY !== 1'b0 || io.COUNT !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got tx %b busy %b count %0d, expected 1 0 0",
               io.UART_TX, io.BUSY, io.COUNT);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (io.UART_TX !== 1'b1 || io.BUSY !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet: got activity %b, expected 0", seen);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    io.UP = 1'b0;
    io.DOWN = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_down_and_both();
    test_coalesce();
    test_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
